matrix_loader: RTL and testbench
================================

# matrix_loader

Memory-side responder to the matrix controller's load handshake. On `load_A_en` it fetches the coefficient matrix A row by row from a wide single-port RAM, hands each row to the ALU, and pulses `load_A_done`. On `load_en` it primes and then streams input-matrix columns, one per cycle, pulsing `load_done` when the first column is valid. It sits between the controller, the data RAM and the ALU operand registers.

## Interface
- `DATA_W`, 8: element width.
- `ROWS`, 4: rows of A; elements per RAM word.
- `N_COLS`, 28: columns of the input matrix per pass.
- `A_BASE`, 0: RAM address of A row 0.
- `X_BASE`, 4: RAM address of input column 0.
- `ADDR_W`, 6: RAM address width.

- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `load_A_en`  in  1  level; request to load A.
- `load_en`  in  1  level; request to prime and stream columns.
- `load_A_done`  out  1  one-cycle pulse; all A rows are written.
- `load_done`  out  1  one-cycle pulse; first column is valid on `x_data`.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_rdata`  in  ROWS*DATA_W  RAM data; valid on the cycle after `mem_rd_en`.
- `a_we`  out  1  A row write strobe to the ALU.
- `a_idx`  out  2  A row index, 0..ROWS-1.
- `a_data`  out  ROWS*DATA_W  A row.
- `x_valid`  out  1  `x_data` holds a valid column.
- `x_data`  out  ROWS*DATA_W  current input column.
- `x_col`  out  5  index of the column currently on `x_data`.
- `err`  out  1  protocol error flag; present only with the macro (see Configuration).

## Operation

Reset (`rst` high at a `clk` edge):
- All outputs are 0, the FSM is in IDLE, `a_loaded` is cleared, and the column counter is 0.
- A reset mid-operation aborts immediately, with no done pulse.

FSM states:
- IDLE
  - `load_A_en` -> FETCH_A.
  - Otherwise `load_en` && `a_loaded` -> PRIME.
  - `load_A_en` has priority when both are high.
  - `load_en` without `a_loaded` is ignored.
- FETCH_A
  - Issues reads at `A_BASE`+0 .. `A_BASE`+ROWS-1 on consecutive cycles.
  - Each returning word drives `a_we`=1 and `a_idx`=row, with `a_data`=`mem_rdata` registered.
  - On the cycle after the last row write: `load_A_done`=1, `a_loaded` is set, -> IDLE.
- PRIME
  - Issues a read of `X_BASE`+0.
  - The next cycle registers the word into `x_data`: `x_valid`=1, `x_col`=0, `load_done`=1 for that cycle.
  - -> STREAM.
- STREAM
  - Each cycle with `load_en`=1, `x_col` advances by 1 and `x_data` takes the prefetched word.
  - The read of column k+1 is issued while column k is presented, so throughput is 1 column per cycle.
  - At `x_col`=N_COLS-1 the next column is 0: the address wraps to `X_BASE` and streaming continues (next row pass).
  - `load_en`=0 -> IDLE: `x_valid`=0, column counter cleared, in-flight prefetch discarded.
  - `load_A_en` is ignored in this state.

Arithmetic:
- Address = base + index, truncated to ADDR_W.
- Column counter is 5 bits and compares against N_COLS-1; no overflow past N_COLS-1.

## Timing
- `load_A_en` is first seen high in cycle t:
  - `mem_rd_en` for rows in cycles t+1..t+ROWS.
  - `a_we` in cycles t+2..t+ROWS+1.
  - `load_A_done` in cycle t+ROWS+2.
- `load_en` is first seen high in cycle t (IDLE):
  - Read in cycle t+1.
  - `x_valid` and `load_done` in cycle t+2.
  - Column 1 in cycle t+3.
- Done pulses last exactly one cycle, regardless of how long the request level stays high.
- When a request is held high after its done pulse and the FSM is back in IDLE, it is treated as a new request; the controller drops the level within one cycle.

## Configuration
- `MATRIX_LOADER_ERR_EN` defined:
  - `err` port exists.
  - `err` is set sticky on `load_en` in IDLE while `a_loaded`=0, or on `load_A_en` during PRIME/STREAM.
  - Cleared only by `rst`.
- Undefined: no `err` port and no error logic; behaviour is otherwise identical.

## Structure
- Shared package `matrix_pkg`: state enum (IDLE, FETCH_A, PRIME, STREAM), `DATA_W`/`ROWS`/`N_COLS` defaults, and the `TOT_COLS` constant shared with the controller.
- One natural sub-module: `loader_addr_gen`, holding the row/column counters, base selection and wrap logic.

## Test plan
- Reset, then `load_A_en` held with RAM rows 0x04030201..: `a_we` for 4 cycles with `a_idx` 0..3, then `load_A_done` pulses once at t+6.
- After A is loaded, `load_en` held 30 cycles: `load_done` at t+2; `x_col` 0..27, then 0,1; `x_data` matches the RAM word per column with no gaps.
- `load_en` with no A loaded: no reads and no `load_done`; `err`=1 with the macro.
- `load_A_en` and `load_en` raised in the same cycle from IDLE: A load runs first, no stream.
- `load_en` dropped at `x_col`=10, then reasserted: restarts at column 0 with a fresh `load_done`.
- `rst` asserted mid FETCH_A at row 2: all outputs 0 next cycle, no `load_A_done`, `a_loaded`=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state type, default sizes and column helper for the matrix load path
package matrix_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_N_COLS = 28;
    localparam int TOT_COLS   = DEF_N_COLS;
    localparam int COL_W      = 5;
    localparam int A_IDX_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_A,
        PRIME,
        STREAM
    } load_state_t;

    typedef logic [COL_W-1:0] col_t;

    // Next column index, wrapping to 0 after the last column of a pass
    function automatic col_t next_col(input col_t col, input int n_cols);
        return (col == col_t'(n_cols - 1)) ? '0 : col + col_t'(1);
    endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// rtl/loader_addr_gen.sv - row phase / column counters and RAM address selection for matrix_loader
module loader_addr_gen
    import matrix_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int N_COLS = DEF_N_COLS,
    parameter int A_BASE = 0,
    parameter int X_BASE = 4,
    parameter int ADDR_W = 6,
    parameter int PH_W   = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  load_state_t       state,
    input  logic              load_en,
    output logic [PH_W-1:0]   phase,
    output col_t              col,
    output logic [ADDR_W-1:0] rd_addr
);

    col_t col_nxt;

    assign col_nxt = next_col(col, N_COLS);

    // Phase counts cycles spent in FETCH_A; the column only advances while streaming with load_en
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            col   <= '0;
        end else begin
            phase <= (state == FETCH_A) ? phase + 1'b1 : '0;
            col   <= (state == STREAM && load_en) ? col_nxt : '0;
        end
    end

    // Address of the word to read this cycle; in STREAM it is the prefetch of the following column
    always_comb begin
        rd_addr = '0;
        case (state)
            FETCH_A: rd_addr = ADDR_W'(A_BASE) + ADDR_W'(phase);
            PRIME:   rd_addr = ADDR_W'(X_BASE);
            STREAM:  rd_addr = ADDR_W'(X_BASE) + ADDR_W'(col_nxt);
            default: rd_addr = '0;
        endcase
    end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - loads matrix A rows and streams input columns from RAM; MATRIX_LOADER_ERR_EN adds the err flag
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int N_COLS = DEF_N_COLS,
    parameter int A_BASE = 0,
    parameter int X_BASE = 4,
    parameter int ADDR_W = 6
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_A_en,
    input  logic                   load_en,
    output logic                   load_A_done,
    output logic                   load_done,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [ROWS*DATA_W-1:0] mem_rdata,
    output logic                   a_we,
    output logic [A_IDX_W-1:0]     a_idx,
    output logic [ROWS*DATA_W-1:0] a_data,
    output logic                   x_valid,
    output logic [ROWS*DATA_W-1:0] x_data,
    output logic [COL_W-1:0]       x_col
`ifdef MATRIX_LOADER_ERR_EN
    ,
    output logic                   err
`endif
);

    localparam int PH_W = $clog2(ROWS + 2);

    load_state_t       state;
    load_state_t       state_nxt;
    logic [PH_W-1:0]   phase;
    logic [ADDR_W-1:0] rd_addr;
    col_t              col;
    logic              a_loaded;
    logic              fetch_rd;
    logic              fetch_last;

    loader_addr_gen #(
        .ROWS   (ROWS),
        .N_COLS (N_COLS),
        .A_BASE (A_BASE),
        .X_BASE (X_BASE),
        .ADDR_W (ADDR_W),
        .PH_W   (PH_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .load_en (load_en),
        .phase   (phase),
        .col     (col),
        .rd_addr (rd_addr)
    );

    // Row reads occupy the first ROWS phases; the final phase waits out the last write before done
    assign fetch_rd   = (state == FETCH_A) && (phase < PH_W'(ROWS));
    assign fetch_last = (state == FETCH_A) && (phase == PH_W'(ROWS + 1));

    // RAM data is presented straight through only while the matching strobe is up, else held at 0
    assign mem_addr = mem_rd_en ? rd_addr : '0;
    assign a_data   = a_we ? mem_rdata : '0;
    assign x_data   = x_valid ? mem_rdata : '0;
    assign x_col    = col;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_nxt   = state;
        mem_rd_en   = 1'b0;
        load_A_done = 1'b0;
        x_valid     = 1'b0;
        case (state)
            IDLE: begin
                if (load_A_en) begin
                    state_nxt = FETCH_A;
                end else if (load_en && a_loaded) begin
                    state_nxt = PRIME;
                end
            end
            FETCH_A: begin
                mem_rd_en = fetch_rd;
                if (fetch_last) begin
                    load_A_done = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            PRIME: begin
                mem_rd_en = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                x_valid   = 1'b1;
                mem_rd_en = load_en;
                if (!load_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A row write strobe trails its read by one cycle; done pulses and a_loaded follow the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            a_we      <= 1'b0;
            a_idx     <= '0;
            a_loaded  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            a_we      <= fetch_rd;
            a_idx     <= fetch_rd ? A_IDX_W'(phase) : '0;
            load_done <= (state == PRIME);
            if (fetch_last) begin
                a_loaded <= 1'b1;
            end
        end
    end

`ifdef MATRIX_LOADER_ERR_EN
    // Sticky protocol error: stream request before A is loaded, or A request while streaming
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == IDLE && load_en && !a_loaded) ||
                     ((state == PRIME || state == STREAM) && load_A_en)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader
`timescale 1ns/1ps
module tb_matrix_loader;

    localparam int DW = 8;
    localparam int RW = 4;
    localparam int NC = 28;
    localparam int AB = 0;
    localparam int XB = 4;
    localparam int AW = 6;
    localparam int WW = RW * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_A_en = 1'b0;
    logic          load_en = 1'b0;
    logic          load_A_done;
    logic          load_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_rdata = '0;
    logic          a_we;
    logic [1:0]    a_idx;
    logic [WW-1:0] a_data;
    logic          x_valid;
    logic [WW-1:0] x_data;
    logic [4:0]    x_col;
`ifdef MATRIX_LOADER_ERR_EN
    logic          err;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rd_cnt = 0;

    typedef enum int {EV_AWR = 0, EV_ADONE = 1, EV_X = 2} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int            cyc;
        int            idx;
        logic [WW-1:0] data;
        logic          first;
    } ev_t;

    ev_t exp_q[$];

    matrix_loader #(
        .DATA_W (DW),
        .ROWS   (RW),
        .N_COLS (NC),
        .A_BASE (AB),
        .X_BASE (XB),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_A_en   (load_A_en),
        .load_en     (load_en),
        .load_A_done (load_A_done),
        .load_done   (load_done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .a_we        (a_we),
        .a_idx       (a_idx),
        .a_data      (a_data),
        .x_valid     (x_valid),
        .x_data      (x_data),
        .x_col       (x_col)
`ifdef MATRIX_LOADER_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM word at address a holds bytes 4a+4, 4a+3, 4a+2, 4a+1 (MSB..LSB)
    function automatic logic [WW-1:0] ram_word(input logic [AW-1:0] a);
        logic [7:0] b;
        b = {a, 2'b00};
        return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
    endfunction

    // Synchronous-read RAM; a poison word appears when no read was issued
    always @(posedge clk) mem_rdata <= mem_rd_en ? ram_word(mem_addr) : 32'hBAD0BAD0;

    function automatic logic [WW-1:0] a_row(input int r);
        case (r)
            0:       return 32'h04030201;
            1:       return 32'h08070605;
            2:       return 32'h0C0B0A09;
            default: return 32'h100F0E0D;
        endcase
    endfunction

    task automatic push(input ev_kind_t kind, input int c, input int idx,
                        input logic [WW-1:0] data, input logic first);
        ev_t e;
        e.kind = kind; e.cyc = c; e.idx = idx; e.data = data; e.first = first;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_kind_t kind, input int idx,
                            input logic [WW-1:0] data, input logic first);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d idx=%0d data=%h first=%0b cyc=%0d, required no event",
                     int'(kind), idx, data, first, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.idx != idx || e.data != data || e.first != first) begin
                fails++;
                $display("FAIL event_k%0d: got kind=%0d cyc=%0d idx=%0d data=%h first=%0b, required kind=%0d cyc=%0d idx=%0d data=%h first=%0b",
                         int'(e.kind), int'(kind), cyc, idx, data, first,
                         int'(e.kind), e.cyc, e.idx, e.data, e.first);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard head
    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (a_we) check_ev(EV_AWR, int'(a_idx), a_data, 1'b0);
        if (load_A_done) check_ev(EV_ADONE, 0, '0, 1'b0);
        if (x_valid) check_ev(EV_X, int'(x_col), x_data, load_done);
        else if (load_done) check_ev(EV_X, -1, '0, 1'b1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic check_zero();
        chk("zero_load_A_done", 64'(load_A_done), 64'd0);
        chk("zero_load_done",   64'(load_done),   64'd0);
        chk("zero_mem_rd_en",   64'(mem_rd_en),   64'd0);
        chk("zero_mem_addr",    64'(mem_addr),    64'd0);
        chk("zero_a_we",        64'(a_we),        64'd0);
        chk("zero_a_idx",       64'(a_idx),       64'd0);
        chk("zero_a_data",      64'(a_data),      64'd0);
        chk("zero_x_valid",     64'(x_valid),     64'd0);
        chk("zero_x_data",      64'(x_data),      64'd0);
        chk("zero_x_col",       64'(x_col),       64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A load request raised this cycle (t); optionally with load_en held alongside
    task automatic load_a(input logic with_x);
        int t;
        t = cyc;
        load_A_en = 1'b1;
        load_en = with_x;
        for (int r = 0; r < RW; r++) push(EV_AWR, t + 2 + r, r, a_row(r), 1'b0);
        push(EV_ADONE, t + RW + 2, 0, '0, 1'b0);
        idle(RW + 3);
        load_A_en = 1'b0;
        load_en = 1'b0;
    endtask

    // Stream request raised this cycle; n columns presented starting at t+2
    task automatic stream(input int n);
        int t;
        int c;
        t = cyc;
        load_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            c = k % NC;
            push(EV_X, t + 2 + k, c, ram_word(AW'(XB + c)), (k == 0));
        end
        idle(n + 1);
        load_en = 1'b0;
    endtask

    task automatic stream_refused(input string name);
        int rd0;
        rd0 = rd_cnt;
        load_en = 1'b1;
        idle(5);
        load_en = 1'b0;
        idle(2);
        chk(name, 64'(rd_cnt - rd0), 64'd0);
    endtask

    initial begin
        int t;
        // Reset state, observed while rst is still held
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero();
`ifdef MATRIX_LOADER_ERR_EN
        chk("err_reset", 64'(err), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Stream request with no A loaded is ignored
        stream_refused("noA_reads");
`ifdef MATRIX_LOADER_ERR_EN
        chk("err_noA", 64'(err), 64'd1);
`endif

        // A load with held request
        load_a(1'b0);
        idle(2);
        chk("drain_A", 64'(exp_q.size()), 64'd0);

        // Full pass plus wrap into the next pass
        stream(30);
        idle(2);
        chk("drain_stream30", 64'(exp_q.size()), 64'd0);

        // Drop at column 10, then restart from column 0 with a fresh load_done
        stream(11);
        idle(2);
        stream(3);
        idle(2);
        chk("drain_restart", 64'(exp_q.size()), 64'd0);

        // Both requests together from IDLE: A load wins, no stream
        load_a(1'b1);
        idle(3);
        chk("drain_both", 64'(exp_q.size()), 64'd0);

        // Reset during FETCH_A while row 2 is being read
        t = cyc;
        load_A_en = 1'b1;
        push(EV_AWR, t + 2, 0, a_row(0), 1'b0);
        push(EV_AWR, t + 3, 1, a_row(1), 1'b0);
        idle(3);
        rst = 1'b1;
        load_A_en = 1'b0;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        chk("drain_rst", 64'(exp_q.size()), 64'd0);

        // a_loaded must have been cleared by the reset
        stream_refused("rst_clears_a_loaded");
`ifdef MATRIX_LOADER_ERR_EN
        chk("err_after_rst", 64'(err), 64'd1);
`endif

        idle(3);
        chk("drain_final", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
